// File: rtl/pcie_led_status_if.sv
// Bundles the PCIe status inputs and LED/status outputs of pcie_led_status.
interface pcie_led_status_if;
  logic       pcie_perst_n;
  logic       link_up;
  logic       rd_strobe;
  logic       wr_strobe;
  logic [3:0] led;
  logic       link_lost;
  logic [1:0] link_state;

  modport master (output pcie_perst_n, link_up, rd_strobe, wr_strobe,
                  input  led, link_lost, link_state);
  modport slave  (input  pcie_perst_n, link_up, rd_strobe, wr_strobe,
                  output led, link_lost, link_state);
endinterface

// File: rtl/pcie_led_status.sv
// Link-state FSM, heartbeat, activity stretchers and sticky link-lost flag
// driving four active-high LEDs (board top inverts onto ledn).
module pcie_led_status #(
  parameter int HB_HALF         = 62500000,
  parameter int STRETCH_CYCLES  = 6250000,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input logic             clk,
  input logic             resetn,
  pcie_led_status_if.slave bus
);
  localparam int HW   = $clog2(HB_HALF);
  localparam int FAST = HB_HALF / 4;
  localparam int FW   = $clog2(FAST + 1);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW   = $clog2(STRETCH_CYCLES + 1);

  typedef enum logic [1:0] {ST_RESET = 2'd0, ST_TRAIN = 2'd1, ST_UP = 2'd2, ST_LOST = 2'd3} state_t;

  logic [1:0]    r_perst_sync, r_lu_sync;
  logic          w_perst_s, w_lu_s;
  logic          r_lu_db;
  logic [DW-1:0] r_dcnt;
  logic [HW-1:0] r_hcnt;
  logic [FW-1:0] r_fcnt;
  logic          r_hb, r_fb;
  state_t        r_state, w_state_nx;
  logic          r_lost, w_lost_nx;
  logic          r_led1;
  logic [SW-1:0] r_scnt [2];
  logic [1:0]    w_strobe;

  // Reset value 0 on the PERST path means "PERST asserted" until proven otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_perst_sync <= '0;
      r_lu_sync    <= '0;
    end else begin
      r_perst_sync <= {r_perst_sync[0], bus.pcie_perst_n};
      r_lu_sync    <= {r_lu_sync[0], bus.link_up};
    end
  end
  assign w_perst_s = r_perst_sync[1];
  assign w_lu_s    = r_lu_sync[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lu_db <= 1'b0;
      r_dcnt  <= '0;
    end else if (w_lu_s == r_lu_db) begin
      r_dcnt <= '0;
    end else if (r_dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
      r_lu_db <= w_lu_s;
      r_dcnt  <= '0;
    end else begin
      r_dcnt <= r_dcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hcnt <= '0;
      r_fcnt <= '0;
      r_hb   <= 1'b0;
      r_fb   <= 1'b0;
    end else begin
      if (r_hcnt == HW'(HB_HALF - 1)) begin
        r_hcnt <= '0;
        r_hb   <= ~r_hb;
      end else begin
        r_hcnt <= r_hcnt + 1'b1;
      end
      if (r_fcnt == FW'(FAST - 1)) begin
        r_fcnt <= '0;
        r_fb   <= ~r_fb;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_RESET;
      r_lost  <= 1'b0;
      r_led1  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_lost  <= w_lost_nx;
      case (r_state)
        ST_RESET: r_led1 <= 1'b0;
        ST_TRAIN: r_led1 <= r_fb;
        ST_UP:    r_led1 <= 1'b1;
        default:  r_led1 <= r_hb;
      endcase
    end
  end

  // PERST low overrides any debounced link change in the same cycle.
  always_comb begin
    w_state_nx = r_state;
    w_lost_nx  = r_lost;
    if (!w_perst_s) begin
      w_state_nx = ST_RESET;
      w_lost_nx  = 1'b0;
    end else begin
      case (r_state)
        ST_RESET: w_state_nx = ST_TRAIN;
        ST_TRAIN: if (r_lu_db) w_state_nx = ST_UP;
        ST_UP: if (!r_lu_db) begin
          w_state_nx = ST_LOST;
          w_lost_nx  = 1'b1;
        end
        default: if (r_lu_db) w_state_nx = ST_UP;
      endcase
    end
  end

  assign w_strobe = {bus.wr_strobe, bus.rd_strobe};

  for (genvar g = 0; g < 2; g++) begin : g_str
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                r_scnt[g] <= '0;
      else if (w_strobe[g])       r_scnt[g] <= SW'(STRETCH_CYCLES);
      else if (r_scnt[g] != '0)   r_scnt[g] <= r_scnt[g] - 1'b1;
    end
  end

  assign bus.led        = {(r_scnt[1] != '0), (r_scnt[0] != '0), r_led1, r_hb};
  assign bus.link_lost  = r_lost;
  assign bus.link_state = r_state;
endmodule

// File: tb/tb_pcie_led_status.sv
// Randomized scoreboard bench for pcie_led_status against a behavioural model.
module tb_pcie_led_status;
  localparam int HB = 8, S = 5, DB = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  pcie_led_status_if bus();

  pcie_led_status #(.HB_HALF(HB), .STRETCH_CYCLES(S), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  typedef struct packed {
    logic [3:0] led;
    logic       lost;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_pass = 0, n_cyc = 0;

  // Model state: elapsed cycles since release, input delay lines, lu_s history window.
  int m_cyc, m_st;
  int m_last[2];
  bit m_ps1, m_ps2, m_lu1, m_lu2, m_db, m_lost, m_led1;
  bit lu_hist[$];

  function automatic void model_reset();
    m_cyc = 0; m_st = 0;
    m_last[0] = -1000; m_last[1] = -1000;
    m_ps1 = 0; m_ps2 = 0; m_lu1 = 0; m_lu2 = 0;
    m_db = 0; m_lost = 0; m_led1 = 0;
    lu_hist.delete();
  endfunction

  function automatic void model_edge();
    bit hb0, fb0, ps, flip;
    int st0;
    hb0 = ((m_cyc / HB) % 2) == 1;
    fb0 = ((m_cyc / (HB / 4)) % 2) == 1;
    st0 = m_st;
    ps  = m_ps2;
    case (st0)
      0: m_led1 = 0;
      1: m_led1 = fb0;
      2: m_led1 = 1;
      default: m_led1 = hb0;
    endcase
    if (!ps) begin
      m_st = 0; m_lost = 0;
    end else begin
      case (st0)
        0: m_st = 1;
        1: if (m_db) m_st = 2;
        2: if (!m_db) begin m_st = 3; m_lost = 1; end
        default: if (m_db) m_st = 2;
      endcase
    end
    // Debounced level flips once DB consecutive synchronized samples disagree with it.
    lu_hist.push_back(m_lu2);
    if (lu_hist.size() > DB) void'(lu_hist.pop_front());
    flip = (lu_hist.size() == DB);
    foreach (lu_hist[i]) if (lu_hist[i] == m_db) flip = 0;
    if (flip) m_db = !m_db;
    m_ps2 = m_ps1; m_ps1 = bus.pcie_perst_n;
    m_lu2 = m_lu1; m_lu1 = bus.link_up;
    m_cyc++;
    if (bus.rd_strobe) m_last[0] = m_cyc;
    if (bus.wr_strobe) m_last[1] = m_cyc;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.led[0] = ((m_cyc / HB) % 2) == 1;
    e.led[1] = m_led1;
    e.led[2] = (m_cyc - m_last[0]) < S;
    e.led[3] = (m_cyc - m_last[1]) < S;
    e.lost   = m_lost;
    e.st     = 2'(m_st);
    return e;
  endfunction

  // One clock: account for the edge just taken, then drive the next inputs.
  task automatic cyc(input bit rn, input bit perst, input bit lu, input bit rd, input bit wr);
    @(posedge clk); #1;
    if (resetn) model_edge();
    resetn = rn;
    if (!rn) model_reset();
    bus.pcie_perst_n = perst;
    bus.link_up      = lu;
    bus.rd_strobe    = rd;
    bus.wr_strobe    = wr;
    sb.push_back(model_out());
  endtask

  task automatic run(input int n, input bit perst, input bit lu, input int pct);
    for (int i = 0; i < n; i++)
      cyc(1, perst, lu, ($urandom % 100) < pct, ($urandom % 100) < pct);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, n_cyc, got, exp);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      n_cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("led", int'(bus.led), int'(e.led));
        chk("link_lost", int'(bus.link_lost), int'(e.lost));
        chk("link_state", int'(bus.link_state), int'(e.st));
      end
    end
  end

  initial begin : driver
    bus.pcie_perst_n = 0; bus.link_up = 0; bus.rd_strobe = 0; bus.wr_strobe = 0;
    model_reset();
    repeat (3) cyc(0, 0, 0, 0, 0);
    run(20, 0, 0, 0);
    run(10, 1, 0, 0);
    run(12, 1, 1, 0);
    run(3, 1, 0, 0);  run(8, 1, 1, 0);
    run(10, 1, 0, 0); run(8, 1, 1, 0);
    run(6, 1, 0, 0);  run(6, 0, 0, 0);
    cyc(1, 0, 0, 1, 0); run(2, 0, 0, 0); cyc(1, 0, 0, 1, 0); run(8, 0, 0, 0);
    cyc(1, 0, 0, 1, 1); run(2, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 1); run(8, 0, 0, 0);
    for (int s = 0; s < 80; s++) begin
      bit rn, pe, lu;
      int len;
      rn  = ($urandom % 20) != 0;
      pe  = ($urandom % 6) != 0;
      lu  = ($urandom % 2) == 1;
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++)
        cyc(rn, pe, lu, ($urandom % 6) == 0, ($urandom % 6) == 0);
    end
    run(4, 1, 1, 0);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) chk("drain", sb.size(), 0);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
